// File: rtl/branch_ctrl_pkg.sv
// Shared types and constants for the branch sequencer: op kinds, FSM states, branch funct3 codes.
package branch_ctrl_pkg;

  typedef enum logic [1:0] {
    BR_KIND_COND = 2'b00,
    BR_KIND_JAL  = 2'b01,
    BR_KIND_JALR = 2'b10,
    BR_KIND_RSVD = 2'b11
  } br_kind_e;

  typedef enum logic [1:0] {
    BRC_ST_IDLE  = 2'b00,
    BRC_ST_EVAL  = 2'b01,
    BRC_ST_REDIR = 2'b10,
    BRC_ST_FLUSH = 2'b11
  } brc_state_e;

  localparam logic [2:0] F3_BR_BEQ  = 3'b000;
  localparam logic [2:0] F3_BR_BNE  = 3'b001;
  localparam logic [2:0] F3_BR_BLT  = 3'b100;
  localparam logic [2:0] F3_BR_BGE  = 3'b101;
  localparam logic [2:0] F3_BR_BLTU = 3'b110;
  localparam logic [2:0] F3_BR_BGEU = 3'b111;

  function automatic logic is_jump_kind(input logic [1:0] kind);
    return (kind == BR_KIND_JAL) || (kind == BR_KIND_JALR);
  endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// Bundle of the issue, branch_unit, redirect and retire signals around branch_ctrl.
interface branch_ctrl_if #(parameter int XLEN = 32);

  logic            br_valid_i;
  logic            br_ready_o;
  logic [1:0]      br_kind_i;
  logic [2:0]      br_f3_i;
  logic [XLEN-1:0] pc_i;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic [2:0]      bu_f3_o;
  logic [XLEN-1:0] bu_op1_o;
  logic [XLEN-1:0] bu_op2_o;
  logic            bu_taken_i;
  logic            redirect_valid_o;
  logic [XLEN-1:0] redirect_pc_o;
  logic            redirect_ready_i;
  logic            flush_o;
  logic            done_o;
  logic            taken_o;
  logic            misalign_o;

  modport slave (
    input  br_valid_i, br_kind_i, br_f3_i, pc_i, imm_i, rs1_i, rs2_i,
           bu_taken_i, redirect_ready_i,
    output br_ready_o, bu_f3_o, bu_op1_o, bu_op2_o, redirect_valid_o,
           redirect_pc_o, flush_o, done_o, taken_o, misalign_o
  );

  modport master (
    output br_valid_i, br_kind_i, br_f3_i, pc_i, imm_i, rs1_i, rs2_i,
           bu_taken_i, redirect_ready_i,
    input  br_ready_o, bu_f3_o, bu_op1_o, bu_op2_o, redirect_valid_o,
           redirect_pc_o, flush_o, done_o, taken_o, misalign_o
  );

endinterface

// File: rtl/branch_ctrl_target_calc.sv
// Combinational target, link address and misalignment flag for a latched branch/jump.
module br_target_calc
  import branch_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      kind,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] target,
  output logic [XLEN-1:0] link,
  output logic            misalign
);

  logic [XLEN-1:0] sum_s;

  // JALR adds to rs1 and clears bit 0; everything else is PC-relative
  always_comb begin
    if (kind == BR_KIND_JALR) begin
      sum_s  = rs1 + imm;
      target = {sum_s[XLEN-1:1], 1'b0};
    end else begin
      sum_s  = pc + imm;
      target = sum_s;
    end
    link     = pc + {{(XLEN-3){1'b0}}, 3'b100};
    misalign = (target[1:0] != 2'b00);
  end

endmodule

// File: rtl/branch_ctrl.sv
// Branch/jump sequencer: drives the shared comparator, resolves direction and redirects fetch.
// Optional backward-taken/forward-not-taken prediction model selected by BR_PRED_BTFN_EN.
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input logic          clk,
  input logic          rst_n,
  branch_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(FLUSH_CYCLES) + 1;

  brc_state_e      state_r;
  brc_state_e      state_nxt_s;
  logic [1:0]      kind_r;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] imm_r;
  logic [XLEN-1:0] rs1_r;
  logic [2:0]      bu_f3_r;
  logic [XLEN-1:0] bu_op1_r;
  logic [XLEN-1:0] bu_op2_r;
  logic [XLEN-1:0] redir_pc_r;
  logic            taken_r;
  logic [CNT_W-1:0] flush_cnt_r;

  logic [XLEN-1:0] target_s;
  logic [XLEN-1:0] link_s;
  logic            target_mis_s;
  logic            taken_s;
  logic            pred_s;
  logic            mispredict_s;
  logic            misalign_s;
  logic            eval_retire_s;
  logic            accept_s;
  logic            redir_ack_s;

  br_target_calc #(.XLEN(XLEN)) u_target_calc (
    .kind     (kind_r),
    .pc       (pc_r),
    .imm      (imm_r),
    .rs1      (rs1_r),
    .target   (target_s),
    .link     (link_s),
    .misalign (target_mis_s)
  );

  assign accept_s    = (state_r == BRC_ST_IDLE) && bus.br_valid_i;
  assign redir_ack_s = (state_r == BRC_ST_REDIR) && bus.redirect_ready_i;

  // Resolved direction versus the direction fetch assumed when it ran ahead
  always_comb begin
    case (kind_r)
      BR_KIND_COND: taken_s = bus.bu_taken_i;
      BR_KIND_JAL:  taken_s = 1'b1;
      BR_KIND_JALR: taken_s = 1'b1;
      default:      taken_s = 1'b0;
    endcase
`ifdef BR_PRED_BTFN_EN
    case (kind_r)
      BR_KIND_COND: pred_s = imm_r[XLEN-1];
      BR_KIND_JAL:  pred_s = 1'b1;
      default:      pred_s = 1'b0;
    endcase
`else
    pred_s = 1'b0;
`endif
    mispredict_s  = taken_s ^ pred_s;
    misalign_s    = taken_s & target_mis_s;
    eval_retire_s = misalign_s | ~mispredict_s;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= BRC_ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      BRC_ST_IDLE: begin
        if (bus.br_valid_i) state_nxt_s = BRC_ST_EVAL;
        else                state_nxt_s = BRC_ST_IDLE;
      end
      BRC_ST_EVAL: begin
        if (eval_retire_s) state_nxt_s = BRC_ST_IDLE;
        else               state_nxt_s = BRC_ST_REDIR;
      end
      BRC_ST_REDIR: begin
        if (bus.redirect_ready_i) state_nxt_s = BRC_ST_FLUSH;
        else                      state_nxt_s = BRC_ST_REDIR;
      end
      BRC_ST_FLUSH: begin
        if (flush_cnt_r == '0) state_nxt_s = BRC_ST_IDLE;
        else                   state_nxt_s = BRC_ST_FLUSH;
      end
      default: state_nxt_s = BRC_ST_IDLE;
    endcase
  end

  // Operand capture, redirect target hold and flush countdown
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kind_r      <= 2'b00;
      pc_r        <= '0;
      imm_r       <= '0;
      rs1_r       <= '0;
      bu_f3_r     <= 3'b000;
      bu_op1_r    <= '0;
      bu_op2_r    <= '0;
      redir_pc_r  <= '0;
      taken_r     <= 1'b0;
      flush_cnt_r <= '0;
    end else begin
      if (accept_s) begin
        kind_r <= bus.br_kind_i;
        pc_r   <= bus.pc_i;
        imm_r  <= bus.imm_i;
        rs1_r  <= bus.rs1_i;
        // Jumps do not use the comparator; park it on a fixed, harmless input
        if (is_jump_kind(bus.br_kind_i)) begin
          bu_f3_r  <= 3'b000;
          bu_op1_r <= '0;
          bu_op2_r <= '0;
        end else begin
          bu_f3_r  <= bus.br_f3_i;
          bu_op1_r <= bus.rs1_i;
          bu_op2_r <= bus.rs2_i;
        end
      end
      if ((state_r == BRC_ST_EVAL) && !eval_retire_s) begin
        redir_pc_r <= taken_s ? target_s : link_s;
        taken_r    <= taken_s;
      end
      if (redir_ack_s) begin
        flush_cnt_r <= CNT_W'(FLUSH_CYCLES - 1);
      end else if ((state_r == BRC_ST_FLUSH) && (flush_cnt_r != '0)) begin
        flush_cnt_r <= flush_cnt_r - CNT_W'(1);
      end
    end
  end

  assign bus.bu_f3_o       = bu_f3_r;
  assign bus.bu_op1_o      = bu_op1_r;
  assign bus.bu_op2_o      = bu_op2_r;
  assign bus.redirect_pc_o = redir_pc_r;

  // Handshake, retire and flush outputs decoded from the state
  always_comb begin
    bus.br_ready_o       = 1'b0;
    bus.redirect_valid_o = 1'b0;
    bus.flush_o          = 1'b0;
    bus.done_o           = 1'b0;
    bus.taken_o          = 1'b0;
    bus.misalign_o       = 1'b0;
    case (state_r)
      BRC_ST_IDLE: bus.br_ready_o = 1'b1;
      BRC_ST_EVAL: begin
        if (eval_retire_s) begin
          bus.done_o     = 1'b1;
          bus.taken_o    = taken_s;
          bus.misalign_o = misalign_s;
        end else begin
          bus.done_o     = 1'b0;
        end
      end
      BRC_ST_REDIR: begin
        bus.redirect_valid_o = 1'b1;
        bus.done_o           = bus.redirect_ready_i;
        bus.taken_o          = bus.redirect_ready_i & taken_r;
      end
      BRC_ST_FLUSH: bus.flush_o = 1'b1;
      default: bus.br_ready_o = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Randomized self-checking bench for branch_ctrl against a transaction-level reference model.
module tb_branch_ctrl;
  import branch_ctrl_pkg::*;

  localparam int XLEN         = 32;
  localparam int FLUSH_CYCLES = 2;

  typedef struct {
    logic [1:0]  kind;
    logic [2:0]  f3;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } op_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  branch_ctrl_if #(.XLEN(XLEN)) bus ();

  branch_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // RISC-V branch comparison rules
  function automatic logic cmp_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Stand-in for the external branch_unit comparator
  always_comb bus.bu_taken_i = cmp_taken(bus.bu_f3_o, bus.bu_op1_o, bus.bu_op2_o);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic void model(input op_t o, output logic tk, output logic mis,
                                output logic redir, output logic [31:0] rpc);
    logic [31:0] tgt;
    logic        pred;
    tk   = (o.kind == 2'b00) ? cmp_taken(o.f3, o.rs1, o.rs2) : (o.kind != 2'b11);
    tgt  = (o.kind == 2'b10) ? ((o.rs1 + o.imm) & 32'hFFFF_FFFE) : (o.pc + o.imm);
`ifdef BR_PRED_BTFN_EN
    pred = (o.kind == 2'b00) ? o.imm[31] : (o.kind == 2'b01);
`else
    pred = 1'b0;
`endif
    mis   = tk && ((tgt % 32'd4) != 32'd0);
    redir = !mis && (tk != pred);
    rpc   = tk ? tgt : (o.pc + 32'd4);
  endfunction

  task automatic drive_op(input op_t o);
    bus.br_valid_i = 1'b1;
    bus.br_kind_i  = o.kind;
    bus.br_f3_i    = o.f3;
    bus.pc_i       = o.pc;
    bus.imm_i      = o.imm;
    bus.rs1_i      = o.rs1;
    bus.rs2_i      = o.rs2;
  endtask

  // Entered and left 2 time units after a rising edge
  task automatic run_op(input op_t o, input int stall);
    logic        tk, mis, redir;
    logic [31:0] rpc;
    int          waited;
    model(o, tk, mis, redir, rpc);
    waited = 0;
    while (bus.br_ready_o !== 1'b1 && waited < 20) begin
      @(posedge clk); #2;
      waited++;
    end
    check_eq("ready_idle", {31'd0, bus.br_ready_o}, 32'd1);
    drive_op(o);
    @(posedge clk); #1;
    // Noise on the issue port while busy must be ignored
    bus.br_valid_i       = 1'($urandom_range(0, 1));
    bus.pc_i             = $urandom();
    bus.rs1_i            = $urandom();
    bus.imm_i            = $urandom();
    bus.br_kind_i        = 2'($urandom_range(0, 3));
    bus.redirect_ready_i = (stall == 0);
    #1;
    check_eq("eval_ready", {31'd0, bus.br_ready_o}, 32'd0);
    check_eq("bu_f3", {29'd0, bus.bu_f3_o}, is_jump_kind(o.kind) ? 32'd0 : {29'd0, o.f3});
    check_eq("bu_op1", bus.bu_op1_o, is_jump_kind(o.kind) ? 32'd0 : o.rs1);
    check_eq("bu_op2", bus.bu_op2_o, is_jump_kind(o.kind) ? 32'd0 : o.rs2);
    check_eq("eval_done", {31'd0, bus.done_o}, {31'd0, !redir});
    check_eq("eval_redir_valid", {31'd0, bus.redirect_valid_o}, 32'd0);
    if (!redir) begin
      check_eq("eval_taken", {31'd0, bus.taken_o}, {31'd0, tk});
      check_eq("eval_misalign", {31'd0, bus.misalign_o}, {31'd0, mis});
    end else begin
      check_eq("eval_misalign_none", {31'd0, bus.misalign_o}, 32'd0);
    end
    @(posedge clk); #1;
    bus.br_valid_i = 1'b0;
    if (!redir) begin
      bus.redirect_ready_i = 1'b0;
      #1;
      check_eq("post_done", {31'd0, bus.done_o}, 32'd0);
      check_eq("post_ready", {31'd0, bus.br_ready_o}, 32'd1);
    end else begin
      for (int c = 0; c <= stall; c++) begin
        if (c > 0) begin
          @(posedge clk); #1;
        end
        bus.redirect_ready_i = (c == stall);
        #1;
        check_eq("redir_valid", {31'd0, bus.redirect_valid_o}, 32'd1);
        check_eq("redir_pc", bus.redirect_pc_o, rpc);
        check_eq("redir_br_ready", {31'd0, bus.br_ready_o}, 32'd0);
        check_eq("redir_done", {31'd0, bus.done_o}, {31'd0, (c == stall)});
        check_eq("redir_flush", {31'd0, bus.flush_o}, 32'd0);
        if (c == stall) check_eq("redir_taken", {31'd0, bus.taken_o}, {31'd0, tk});
      end
      for (int f = 0; f < FLUSH_CYCLES; f++) begin
        @(posedge clk); #1;
        bus.redirect_ready_i = 1'($urandom_range(0, 1));
        #1;
        check_eq("flush_on", {31'd0, bus.flush_o}, 32'd1);
        check_eq("flush_done", {31'd0, bus.done_o}, 32'd0);
        check_eq("flush_redir_valid", {31'd0, bus.redirect_valid_o}, 32'd0);
      end
      @(posedge clk); #1;
      bus.redirect_ready_i = 1'b0;
      #1;
      check_eq("flush_off", {31'd0, bus.flush_o}, 32'd0);
      check_eq("flush_end_ready", {31'd0, bus.br_ready_o}, 32'd1);
    end
  endtask

  function automatic op_t mk_op(input logic [1:0] kind, input logic [2:0] f3, input logic [31:0] pc,
                                input logic [31:0] imm, input logic [31:0] rs1, input logic [31:0] rs2);
    op_t o;
    o.kind = kind; o.f3 = f3; o.pc = pc; o.imm = imm; o.rs1 = rs1; o.rs2 = rs2;
    return o;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0] f3_tab [8];
    op_t        o;
    int         v;
    f3_tab = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010, 3'b011};
    bus.br_valid_i = 1'b0; bus.br_kind_i = 2'b00; bus.br_f3_i = 3'b000;
    bus.pc_i = '0; bus.imm_i = '0; bus.rs1_i = '0; bus.rs2_i = '0;
    bus.redirect_ready_i = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_eq("rst_ready", {31'd0, bus.br_ready_o}, 32'd1);
    check_eq("rst_done", {31'd0, bus.done_o}, 32'd0);
    check_eq("rst_flush", {31'd0, bus.flush_o}, 32'd0);
    check_eq("rst_redir_valid", {31'd0, bus.redirect_valid_o}, 32'd0);
    check_eq("rst_redir_pc", bus.redirect_pc_o, 32'd0);
    check_eq("rst_bu_op1", bus.bu_op1_o, 32'd0);
    check_eq("rst_misalign", {31'd0, bus.misalign_o}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #2;

    run_op(mk_op(2'b00, F3_BR_BEQ, 32'h100, 32'h20, 32'd5, 32'd5), 0);
    run_op(mk_op(2'b00, F3_BR_BLT, 32'h200, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'd1), 1);
    run_op(mk_op(2'b00, F3_BR_BGEU, 32'h200, 32'hFFFF_FFF8, 32'd1, 32'd2), 0);
    run_op(mk_op(2'b10, 3'b000, 32'h300, 32'd2, 32'h1001, 32'd0), 0);
    run_op(mk_op(2'b00, F3_BR_BEQ, 32'h100, 32'h20, 32'd5, 32'd5), 3);
    run_op(mk_op(2'b11, 3'b000, 32'h400, 32'h10, 32'd0, 32'd0), 0);
    run_op(mk_op(2'b01, 3'b000, 32'hFFFF_FFF0, 32'h20, 32'd0, 32'd0), 2);

    // Reset in the middle of a flush drops the op without retiring it
    drive_op(mk_op(2'b00, F3_BR_BNE, 32'h500, 32'h40, 32'd1, 32'd2));
    @(posedge clk); #1;
    bus.br_valid_i = 1'b0;
    bus.redirect_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("abort_in_flush", {31'd0, bus.flush_o}, 32'd1);
    rst_n = 1'b0;
    bus.redirect_ready_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check_eq("abort_ready", {31'd0, bus.br_ready_o}, 32'd1);
    check_eq("abort_flush", {31'd0, bus.flush_o}, 32'd0);
    check_eq("abort_done", {31'd0, bus.done_o}, 32'd0);
    check_eq("abort_redir_valid", {31'd0, bus.redirect_valid_o}, 32'd0);

    for (int n = 0; n < 300; n++) begin
      o.kind = 2'($urandom_range(0, 3));
      o.f3   = f3_tab[$urandom_range(0, 7)];
      o.rs1  = $urandom();
      o.rs2  = ($urandom_range(0, 3) == 0) ? o.rs1 : $urandom();
      if ($urandom_range(0, 3) == 0) o.rs2 = o.rs1 ^ 32'h8000_0000;
      o.pc   = $urandom() & 32'hFFFF_FFFC;
      v      = int'($urandom_range(0, 8191)) - 4096;
      o.imm  = v;
      if ($urandom_range(0, 3) != 0) o.imm = o.imm & 32'hFFFF_FFFC;
      run_op(o, int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
